// File: rtl/spi_state_machine.sv
`default_nettype none
// ============================================================================
//  Module   : spi_state_machine
//  Purpose  : Free-running write-only SPI master (mode 0). Serialises data_in
//             MSB-first with sclk = clk/2, framed by active-low chip select.
//  Revision : 1.0  initial release
// ============================================================================
module spi_state_machine #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  spi_sclk,
    output logic                  spi_cs_l,
    output logic                  spi_data,
    output logic [5:0]            counter
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] c_last_count = 6'(2 * DATA_WIDTH - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // The next bit to present is always the MSB of the word shifted once more.
    assign w_shift_next = r_shift << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            spi_cs_l <= 1'b1;
            spi_sclk <= 1'b0;
            spi_data <= 1'b0;
            counter  <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    spi_cs_l <= 1'b1;
                    spi_sclk <= 1'b0;
                    spi_data <= 1'b0;
                    counter  <= 6'd0;
                    r_state  <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift  <= data_in;
                    spi_cs_l <= 1'b0;
                    spi_sclk <= 1'b0;
                    spi_data <= data_in[DATA_WIDTH-1];
                    counter  <= 6'd0;
                    r_state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (counter == c_last_count) begin
                        spi_sclk <= 1'b0;
                        counter  <= 6'd0;
                        r_state  <= ST_DONE;
                    end else begin
                        spi_sclk <= ~spi_sclk;
                        counter  <= counter + 6'd1;
                        // Odd index = sclk falling edge: advance to next bit.
                        if (counter[0]) begin
                            r_shift  <= w_shift_next;
                            spi_data <= w_shift_next[DATA_WIDTH-1];
                        end
                    end
                end
                ST_DONE: begin
                    spi_cs_l <= 1'b1;
                    spi_sclk <= 1'b0;
                    spi_data <= 1'b0;
                    counter  <= 6'd0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_state_machine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_state_machine
//  Purpose  : Self-checking bench; frame-position reference model for the SPI
//             transmitter, plus slave-side word capture and frame spacing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_state_machine;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        spi_sclk;
    logic        spi_cs_l;
    logic        spi_data;
    logic [5:0]  counter;

    spi_state_machine #(.DATA_WIDTH(16)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .spi_sclk (spi_sclk),
        .spi_cs_l (spi_cs_l),
        .spi_data (spi_data),
        .counter  (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          k        = 0;      // clk edges since the last reset edge
    int          cyc      = 0;
    logic [15:0] latched  = 16'h0;  // word the model believes is in flight
    logic [15:0] cap      = 16'h0;  // bits seen by a mode-0 slave
    int          nb       = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;
    int          last_fall = 0;
    logic        fall_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame is 35 edges long: position 1 = IDLE->LOAD, 2 = LOAD done,
    // 2..34 = shift window, 0 = chip select released.
    task automatic step(input logic rst_v, input logic [15:0] din);
        int   q;
        int   j;
        int   b;
        logic e_cs;
        logic e_sclk;
        logic e_data;
        logic [5:0] e_cnt;
        @(negedge clk);
        reset   = rst_v;
        data_in = din;
        @(posedge clk);
        cyc++;
        if (rst_v) begin
            k       = 0;
            latched = 16'h0;
        end else begin
            k++;
            if (k % 35 == 2) latched = din;
        end
        q      = k % 35;
        e_cs   = 1'b1;
        e_sclk = 1'b0;
        e_data = 1'b0;
        e_cnt  = 6'd0;
        if (k > 0 && q >= 2) begin
            j    = q - 2;
            e_cs = 1'b0;
            if (j < 32) begin
                e_sclk = j[0];
                e_cnt  = 6'(j);
            end
            b      = (j / 2 > 15) ? 15 : j / 2;
            e_data = latched[15 - b];
        end
        #1;
        chk("cs_l",    32'(spi_cs_l), 32'(e_cs));
        chk("sclk",    32'(spi_sclk), 32'(e_sclk));
        chk("data",    32'(spi_data), 32'(e_data));
        chk("counter", 32'(counter),  32'(e_cnt));
        chk("sclk_while_cs_high", 32'(spi_sclk & spi_cs_l), 32'd0);

        if (rst_v) begin
            nb         = 0;
            fall_valid = 1'b0;
        end else begin
            if (!prev_sclk && spi_sclk) begin
                cap = {cap[14:0], spi_data};
                nb++;
                if (nb == 16) begin
                    chk("frame_word", 32'(cap), 32'(latched));
                    nb = 0;
                end
            end
            if (prev_cs && !spi_cs_l) begin
                if (fall_valid) chk("frame_period", 32'(cyc - last_fall), 32'd35);
                last_fall  = cyc;
                fall_valid = 1'b1;
            end
            if (!prev_cs && spi_cs_l) chk("edges_per_frame", 32'(nb), 32'd0);
        end
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_l;
    endtask

    initial begin
        logic [15:0] d;
        logic        found;
        reset   = 1'b1;
        data_in = 16'h0;

        step(1'b1, 16'hFFF0);
        step(1'b1, 16'hFFF0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'hFFF0);
        // Change data mid-shift; current frame must stay 0xFFF0.
        for (int i = 0; i < 60; i++) step(1'b0, 16'd2000);
        for (int i = 0; i < 110; i++) step(1'b0, 16'd3000);

        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1'b0, 16'd3000);
            if (counter == 6'd10) found = 1'b1;
        end
        chk("reached_counter10", 32'(found), 32'd1);
        step(1'b1, 16'd3000);
        for (int i = 0; i < 40; i++) step(1'b0, 16'd3000);

        for (int i = 0; i < 75; i++) step(1'b0, 16'h8001);

        d = 16'(($urandom));
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) d = 16'($urandom);
            step(($urandom_range(0, 149) == 0), d);
        end
        for (int i = 0; i < 40; i++) step(1'b0, d);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
